// File: rtl/axi_lite_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one AXI-Lite master.
// Define ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise D_FIRST fixes priority.
module axi_lite_arbiter #(
    parameter bit D_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] rsp_data,
    output logic        i_done,
    output logic        d_done,
    output logic        rsp_err,
    output logic [31:0] addr,
    output logic        awvalid,
    input  logic        awready,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic        bresp,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic        rresp
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_e;

    state_e          state_q, state_d;
    logic            win_d_q, win_d_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            i_done_q, i_done_d;
    logic            d_done_q, d_done_d;
    logic            grant_c;
    logic            pick_d_c;
    logic            aw_pend_c;
    logic            w_pend_c;

    // Arbitrate only in IDLE and never in the cycle a done pulses.
    assign grant_c = (state_q == IDLE) && !i_done_q && !d_done_q && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
    logic prefer_d_q, prefer_d_d;

    assign pick_d_c   = d_req && (!i_req || prefer_d_q);
    assign prefer_d_d = grant_c ? !pick_d_c : prefer_d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prefer_d_q <= 1'b1;
        else        prefer_d_q <= prefer_d_d;
    end
`else
    assign pick_d_c = d_req && (!i_req || D_FIRST);
`endif

    assign aw_pend_c = awvalid_q && !awready;
    assign w_pend_c  = wvalid_q && !wready;

    always_comb begin
        state_d    = state_q;
        win_d_d    = win_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_c) begin
                    win_d_d = pick_d_c;
                    if (pick_d_c) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (d_we) begin
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            state_d   = WADDR;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = RADDR;
                        end
                    end else begin
                        addr_d    = i_addr;
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            // rready only rises after the address handshake, so early rvalid waits.
            RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (rvalid) begin
                    rready_d   = 1'b0;
                    rsp_data_d = rdata;
                    rsp_err_d  = rresp;
                    i_done_d   = !win_d_q;
                    d_done_d   = win_d_q;
                    state_d    = IDLE;
                end
            end
            WADDR: begin
                awvalid_d = aw_pend_c;
                wvalid_d  = w_pend_c;
                if (!aw_pend_c && !w_pend_c) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    bready_d   = 1'b0;
                    rsp_data_d = '0;
                    rsp_err_d  = bresp;
                    i_done_d   = !win_d_q;
                    d_done_d   = win_d_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            win_d_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_d_q    <= win_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign wstrb    = 4'b1111;
    assign awvalid  = awvalid_q;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; honours ARB_ROUND_ROBIN_EN for tie expectations.
module tb_axi_lite_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] rsp_data, addr, wdata, rdata;
    logic        i_done, d_done, rsp_err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, bresp;
    logic        arvalid, arready, rvalid, rready, rresp;
    logic [3:0]  wstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .rsp_data(rsp_data), .i_done(i_done), .d_done(d_done), .rsp_err(rsp_err),
        .addr(addr), .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
        .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp)
    );

    task automatic clear_slave();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        clear_slave();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Slave side of one transaction: ready/valid after the given cycle delays; reports what it saw.
    task automatic serve(input int d1, input int d2, input int d3,
                         input logic [31:0] rd, input logic er,
                         output logic wr, output logic [31:0] a_seen, output logic [31:0] w_seen,
                         output logic gi, output logic gd, output logic [31:0] rdat,
                         output logic rerr, output bit ok, output int lat, output int ncyc);
        bit a_hs, b_hs, fin, started;
        ok = 1'b1; gi = 1'b0; gd = 1'b0; wr = 1'b0; a_seen = '0; w_seen = '0;
        rdat = '0; rerr = 1'b0; lat = -1; ncyc = -1; started = 1'b0;
        for (int k = 0; k < 30 && !started; k++) begin
            @(negedge clk);
            if (arvalid || awvalid || wvalid) begin
                started = 1'b1;
                lat = k + 1;
            end
        end
        if (!started) begin
            ok = 1'b0;
            return;
        end
        wr = awvalid || wvalid; a_seen = addr; w_seen = wdata;
        a_hs = 1'b0; b_hs = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (fin) begin
                gi = i_done; gd = d_done; rdat = rsp_data; rerr = rsp_err; ncyc = cyc;
                if (bready || rready || arvalid || awvalid || wvalid) ok = 1'b0;
                clear_slave();
                return;
            end
            if (i_done || d_done || addr !== a_seen || wstrb !== 4'hF) ok = 1'b0;
            if (!wr) begin
                if (arvalid !== !a_hs || rready !== a_hs) ok = 1'b0;
                arready = !a_hs && cyc >= d1;
                rvalid  = cyc >= d1 + d2;
                rdata   = rd; rresp = er;
                fin     = rvalid && rready;
                if (arvalid && arready) a_hs = 1'b1;
            end else begin
                if (wdata !== w_seen) ok = 1'b0;
                if (awvalid !== !a_hs || wvalid !== !b_hs) ok = 1'b0;
                if (bready !== (a_hs && b_hs)) ok = 1'b0;
                awready = !a_hs && cyc >= d1;
                wready  = !b_hs && cyc >= d2;
                bvalid  = a_hs && b_hs && cyc >= d3;
                bresp   = er;
                fin     = bvalid && bready;
                if (awvalid && awready) a_hs = 1'b1;
                if (wvalid && wready)   b_hs = 1'b1;
            end
        end
        ok = 1'b0;
        clear_slave();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        clear_slave();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, i_done, d_done, rsp_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {awvalid, wvalid, bready, arvalid, rready, i_done, d_done, rsp_err});
        end
        n_cmp++;
        if ({addr, wdata, rsp_data} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h want zeros", addr, wdata, rsp_data);
        end
        n_cmp++;
        if (wstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL wstrb: got %h want f", wstrb);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lone_fetch();
        logic wr, gi, gd, rerr; logic [31:0] a_s, w_s, rdat; bit ok; int lat, nc;
        i_addr = 32'h100; i_req = 1'b1;
        serve(0, 2, 0, 32'h13, 1'b0, wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
        i_req = 1'b0;
        n_cmp++;
        if (!ok || lat != 1 || nc != 3) begin
            n_fail++;
            $display("FAIL fetch_timing: got ok=%0d lat=%0d ncyc=%0d want 1 1 3", ok, lat, nc);
        end
        n_cmp++;
        if ({wr, gi, gd, rerr} !== 4'b0100 || a_s !== 32'h100 || rdat !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_result: got wr/gi/gd/err=%b addr=%h data=%h want 0100 100 13",
                     {wr, gi, gd, rerr}, a_s, rdat);
        end
        @(negedge clk);
        n_cmp++;
        if (i_done !== 1'b0 || rsp_data !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_pulse: got i_done=%b data=%h want 0 13", i_done, rsp_data);
        end
    endtask

    task automatic test_store_skew();
        logic wr, gi, gd, rerr; logic [31:0] a_s, w_s, rdat; bit ok; int lat, nc;
        d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
        serve(3, 0, 1, 32'h0, 1'b0, wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
        d_req = 1'b0;
        n_cmp++;
        if (!ok || lat != 1 || nc != 5) begin
            n_fail++;
            $display("FAIL store_timing: got ok=%0d lat=%0d ncyc=%0d want 1 1 5", ok, lat, nc);
        end
        n_cmp++;
        if ({wr, gi, gd, rerr} !== 4'b1010 || a_s !== 32'h2000 || w_s !== 32'hDEADBEEF
            || rdat !== 32'h0) begin
            n_fail++;
            $display("FAIL store_result: got %b addr=%h wdata=%h data=%h want 1010 2000 deadbeef 0",
                     {wr, gi, gd, rerr}, a_s, w_s, rdat);
        end
        @(negedge clk);
        n_cmp++;
        if (d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pulse: got d_done=%b want 0", d_done);
        end
    endtask

    task automatic test_error();
        logic wr, gi, gd, rerr; logic [31:0] a_s, w_s, rdat; bit ok; int lat, nc;
        d_we = 1'b0; d_addr = 32'h3000; d_req = 1'b1;
        serve(1, 1, 0, 32'hCAFE0001, 1'b1, wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
        d_req = 1'b0;
        n_cmp++;
        if (!ok || {wr, gi, gd, rerr} !== 4'b0011 || rdat !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL load_err: got ok=%0d %b data=%h want 1 0011 cafe0001",
                     ok, {wr, gi, gd, rerr}, rdat);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL err_hold: got err=%b data=%h want 1 cafe0001", rsp_err, rsp_data);
        end
        i_addr = 32'h104; i_req = 1'b1;
        serve(0, 0, 0, 32'h0000_0AAA, 1'b0, wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
        i_req = 1'b0;
        n_cmp++;
        if (!ok || {gi, gd, rerr} !== 3'b100 || rdat !== 32'h0AAA) begin
            n_fail++;
            $display("FAIL err_clear: got ok=%0d %b data=%h want 1 100 aaa", ok, {gi, gd, rerr}, rdat);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic wr, gi, gd, rerr; logic [31:0] a_s, w_s, rdat, rd; bit ok, exp_d; int lat, nc;
        do_reset();
        i_addr = 32'h1000; i_req = 1'b1;
        d_addr = 32'h2000; d_we = 1'b0; d_req = 1'b1;
        for (int t = 0; t < 5; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (t < 4) && (t % 2 == 0);
`else
            exp_d = (t < 4);
`endif
            rd = $urandom;
            serve($urandom_range(0, 2), $urandom_range(0, 2), 0, rd, 1'b0,
                  wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
            if (t == 3) d_req = 1'b0;
            n_cmp++;
            if (!ok || gd !== exp_d || gi !== !exp_d || rdat !== rd
                || a_s !== (exp_d ? 32'h2000 : 32'h1000)) begin
                n_fail++;
                $display("FAIL tie_%0d: got ok=%0d gd=%b gi=%b addr=%h data=%h want gd=%b data=%h",
                         t, ok, gd, gi, a_s, rdat, exp_d, rd);
            end
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic wr, gi, gd, rerr; logic [31:0] a_s, w_s, rdat; bit ok, seen; int lat, nc;
        i_addr = 32'h200; i_req = 1'b1; seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = arvalid;
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        n_cmp++;
        if (!seen || rready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got arvalid_seen=%0d rready=%b want 1 1", seen, rready);
        end
        rvalid = 1'b1; rdata = 32'h55; reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({i_done, d_done, awvalid, wvalid, bready, arvalid, rready} !== 7'h00) begin
                n_fail++;
                $display("FAIL mid_reset_%0d: got %b want 0000000", k,
                         {i_done, d_done, awvalid, wvalid, bready, arvalid, rready});
            end
        end
        reset = 1'b1; i_req = 1'b0; clear_slave();
        @(negedge clk);
        n_cmp++;
        if ({i_done, d_done, rsp_data} !== 34'h0) begin
            n_fail++;
            $display("FAIL mid_release: got done=%b%b data=%h want 00 0", i_done, d_done, rsp_data);
        end
        i_addr = 32'h300; i_req = 1'b1;
        serve(1, 1, 0, 32'h77, 1'b0, wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
        i_req = 1'b0;
        n_cmp++;
        if (!ok || lat != 1 || {gi, gd} !== 2'b10 || a_s !== 32'h300 || rdat !== 32'h77) begin
            n_fail++;
            $display("FAIL mid_refetch: got ok=%0d lat=%0d %b addr=%h data=%h want 1 1 10 300 77",
                     ok, lat, {gi, gd}, a_s, rdat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic wr, gi, gd, rerr, er, exp_wr; logic [31:0] a_s, w_s, rdat, rd, exp_a, exp_rd;
        bit ok, last_d, want_i, want_d, cur_d; int lat, nc, d1, d2, d3, pat, m, exp_nc;
        do_reset();
        last_d = 1'b0;
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            pat = $urandom_range(1, 3);
            want_i = pat[0]; want_d = pat[1];
            i_addr = $urandom & 32'hFFFF_FFFC; d_addr = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom; d_we = $urandom_range(0, 1);
            i_req = want_i; d_req = want_d;
            for (int k = 0; k < 2 && (want_i || want_d); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
                cur_d = want_d && (!want_i || !last_d);
`else
                cur_d = want_d;
`endif
                d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3); d3 = $urandom_range(0, 3);
                rd = $urandom; er = $urandom_range(0, 1);
                exp_wr = cur_d && d_we;
                exp_a  = cur_d ? d_addr : i_addr;
                exp_rd = exp_wr ? 32'h0 : rd;
                if (exp_wr) begin
                    m = ((d1 > d2) ? d1 : d2) + 1;
                    exp_nc = ((d3 > m) ? d3 : m) + 1;
                end else begin
                    exp_nc = d1 + ((d2 > 1) ? d2 : 1) + 1;
                end
                serve(d1, d2, d3, rd, er, wr, a_s, w_s, gi, gd, rdat, rerr, ok, lat, nc);
                last_d = cur_d;
                if (cur_d) begin d_req = 1'b0; want_d = 1'b0; end
                else       begin i_req = 1'b0; want_i = 1'b0; end
                n_cmp++;
                if (!ok || gd !== cur_d || gi !== !cur_d || wr !== exp_wr || a_s !== exp_a
                    || (exp_wr && w_s !== d_wdata) || rdat !== exp_rd || rerr !== er
                    || nc != exp_nc || (k == 0 && lat != 1)) begin
                    n_fail++;
                    $display("FAIL rand_%0d_%0d: got ok=%0d gd=%b wr=%b addr=%h data=%h err=%b nc=%0d lat=%0d want gd=%b wr=%b addr=%h data=%h err=%b nc=%0d",
                             it, k, ok, gd, wr, a_s, rdat, rerr, nc, lat,
                             cur_d, exp_wr, exp_a, exp_rd, er, exp_nc);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_skew();
        test_error();
        test_tie();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
